if_id_stage: RTL

- Instruction-fetch sequencer and IF/ID pipeline register. It sits between the PC-select logic (next_pc comes from the fetch-stage PC mux) and the decode stage.
- Owns the fetch address register and drives a single-outstanding-request handshake to instruction memory.
- Captures fetched instructions into the IF/ID register, using a one-entry skid buffer to absorb decode stalls.
- Discards in-flight or buffered instructions on a redirect (flush).

---
 rtl/lc3b_types.sv | 18 +
 rtl/if_skid_buffer.sv | 36 +++
 rtl/plus2.sv | 9 +
 rtl/if_id_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types.
//   lc3b_fetch_state : fetch sequencer state (FETCH, BUFFERED, DRAIN)
//   lc3b_if_id       : IF/ID pipeline register contents {valid, ir, pc}
package lc3b_types;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2
    } lc3b_fetch_state;

    typedef struct packed {
        logic        valid;
        logic [15:0] ir;
        logic [15:0] pc;
    } lc3b_if_id;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register used to park a value while the consumer stalls.
//   clk, reset_n : clock, async active-low reset (clears the entry)
//   load_i       : capture d_i and mark full
//   clear_i      : drop the entry (load wins if both asserted)
//   d_i / q_o    : data in / held data
//   full_o       : entry holds a value
module if_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         full_o
);
    logic [W-1:0] data_q;
    logic         full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= d_i;
            full_q <= 1'b1;
        end else if (clear_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end
    end

    assign q_o    = data_q;
    assign full_o = full_q;
endmodule

// File: rtl/plus2.sv
// Sequential-PC adder: out = in + 2, wrapping modulo 2^16.
//   in_i  : 16-bit address
//   out_o : in_i + 2
module plus2 (
    input  logic [15:0] in_i,
    output logic [15:0] out_o
);
    assign out_o = in_i + 16'd2;
endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch sequencer and IF/ID pipeline register.
// Keeps one outstanding request to instruction memory, captures responses
// into IF/ID, parks one response in a skid buffer when decode stalls, and
// drains/discards in-flight work on flush.
//   clk, reset_n          : clock, async active-low reset
//   next_pc               : next fetch address from the PC mux
//   flush, stall          : redirect request / decode back-pressure
//   imem_read/imem_address: memory request (Moore, registered address)
//   imem_rdata/imem_resp  : memory response (single-cycle pulse)
//   if_id_valid/ir/pc     : IF/ID register (pc = fetch address + 2)
//   fetch_pc              : current request address
module if_id_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] next_pc,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_id_valid,
    output logic [15:0] if_id_ir,
    output logic [15:0] if_id_pc,
    output logic [15:0] fetch_pc
);
    lc3b_fetch_state state_q, state_d;
    logic [15:0]     req_addr_q, req_addr_d;
    logic [15:0]     redirect_pc_q, redirect_pc_d;
    lc3b_if_id       if_id_q, if_id_d;

    logic [15:0] req_addr_p2;
    logic        skid_load, skid_clear, skid_full;
    logic [31:0] skid_q;

    plus2 u_plus2 (
        .in_i  (req_addr_q),
        .out_o (req_addr_p2)
    );

    if_skid_buffer #(.W(32)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     ({imem_rdata, req_addr_p2}),
        .q_o     (skid_q),
        .full_o  (skid_full)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        redirect_pc_d = redirect_pc_q;
        if_id_d       = if_id_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;

        // Decode takes the current instruction; any load below overrides this.
        if (if_id_q.valid && !stall)
            if_id_d.valid = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (flush) begin
                    if_id_d.valid = 1'b0;
                    if (imem_resp) begin
                        req_addr_d = next_pc;
                    end else begin
                        // Request still pending: it must complete before we
                        // can retarget, so remember where to go.
                        redirect_pc_d = next_pc;
                        state_d       = DRAIN;
                    end
                end else if (imem_resp) begin
                    req_addr_d = next_pc;
                    if (!if_id_q.valid || !stall) begin
                        if_id_d = '{valid: 1'b1, ir: imem_rdata, pc: req_addr_p2};
                    end else begin
                        skid_load = 1'b1;
                        state_d   = BUFFERED;
                    end
                end
            end
            BUFFERED: begin
                if (flush) begin
                    skid_clear    = 1'b1;
                    if_id_d.valid = 1'b0;
                    req_addr_d    = next_pc;
                    state_d       = FETCH;
                end else if (!stall && skid_full) begin
                    if_id_d    = '{valid: 1'b1, ir: skid_q[31:16], pc: skid_q[15:0]};
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (flush)
                    redirect_pc_d = next_pc;
                if (imem_resp) begin
                    req_addr_d = flush ? next_pc : redirect_pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            req_addr_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            if_id_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            redirect_pc_q <= redirect_pc_d;
            if_id_q       <= if_id_d;
        end
    end

    assign imem_read    = (state_q != BUFFERED);
    assign imem_address = req_addr_q;
    assign fetch_pc     = req_addr_q;
    assign if_id_valid  = if_id_q.valid;
    assign if_id_ir     = if_id_q.ir;
    assign if_id_pc     = if_id_q.pc;
endmodule
